program_loader: RTL

- Producer end of the program-memory load port: receives a byte stream over a valid/ready handshake and assembles 12-bit instructions from byte pairs.
- Writes each instruction into PMem through the load address, load instruction and load enable lines, then checks a trailing XOR checksum.
- Signals load completion to the controller's LOAD stage, so programs are loaded at run time instead of from a simulation file.

---
 rtl/program_loader.sv | 79 +++++++
 1 files changed

// File: rtl/program_loader.sv
// program_loader: assembles byte pairs from a valid/ready stream into PMem load writes,
// then verifies a trailing XOR checksum and reports done or error.
module program_loader #(
    parameter int INST_W = 12,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [ADDR_W-1:0] load_addr,
    output logic [INST_W-1:0] load_inst,
    output logic              load_we,
    output logic              load_done,
    output logic              load_err,
    output logic              busy
);
    typedef enum logic [2:0] {IDLE, HI, LO, WRITE, CSUM, DONE, ERR} state_t;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
    state_t          state;
    logic [7:0]      acc;
    logic [INST_W-9:0] hi;
    // Outputs are registered alongside the state, so each is set on entry to the state that owns it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            acc       <= '0;
            hi        <= '0;
            rx_ready  <= 1'b0;
            load_addr <= '0;
            load_inst <= '0;
            load_we   <= 1'b0;
            load_done <= 1'b0;
            load_err  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            load_we <= 1'b0;
            case (state)
                IDLE, DONE, ERR: if (start) begin
                    state     <= HI;
                    acc       <= '0;
                    load_addr <= '0;
                    load_done <= 1'b0;
                    load_err  <= 1'b0;
                    busy      <= 1'b1;
                    rx_ready  <= 1'b1;
                end
                HI: if (rx_valid) begin
                    hi    <= rx_data[INST_W-9:0];
                    acc   <= acc ^ rx_data;
                    state <= LO;
                end
                LO: if (rx_valid) begin
                    load_inst <= {hi, rx_data};
                    acc       <= acc ^ rx_data;
                    load_we   <= 1'b1;
                    rx_ready  <= 1'b0;
                    state     <= WRITE;
                end
                WRITE: begin
                    rx_ready  <= 1'b1;
                    state     <= load_addr == LAST ? CSUM : HI;
                    load_addr <= load_addr == LAST ? load_addr : load_addr + 1'b1;
                end
                CSUM: if (rx_valid) begin
                    rx_ready  <= 1'b0;
                    busy      <= 1'b0;
                    load_done <= rx_data == acc;
                    load_err  <= rx_data != acc;
                    state     <= rx_data == acc ? DONE : ERR;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
